// File: rtl/mest_pro_pkg.sv
`default_nettype none
// ============================================================================
// mest_pro_pkg : shared sizes and loader state type for the MEST Pro IMEM
// Revision     : 1.0
// ============================================================================
package mest_pro_pkg;

  localparam int OP_CODE_SIZE        = 4;
  localparam int INSTRUCTION_SIZE    = OP_CODE_SIZE + 24;
  localparam int LOAD_BYTE_W         = 8;
  localparam int LOAD_BYTES_PER_WORD = 4;
  // Byte 0 of each word contributes only its low nibble, landing at this bit.
  localparam int LOAD_NIBBLE_LSB     = 24;

  typedef enum logic [1:0] {
    L_IDLE  = 2'd0,
    L_BYTE  = 2'd1,
    L_WRITE = 2'd2,
    L_DONE  = 2'd3
  } load_state_t;

endpackage
`default_nettype wire

// File: rtl/mest_pro_imem_loader.sv
`default_nettype none
// ============================================================================
// mest_pro_imem_loader : byte-serial program loader (FSM, assembler, counter)
// Revision             : 1.0
// ============================================================================
module mest_pro_imem_loader
  import mest_pro_pkg::*;
#(
  parameter int INSTR_W    = INSTRUCTION_SIZE,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = 16,
  parameter int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic [ADDR_WIDTH:0] len_i,
  input  logic               valid_i,
  input  logic [7:0]         byte_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               we_o,
  output logic [IDX_W-1:0]   waddr_o,
  output logic [INSTR_W-1:0] wdata_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [1:0]          LAST_BYTE = 2'(LOAD_BYTES_PER_WORD - 1);

  load_state_t          state_q, state_d;
  logic [ADDR_WIDTH:0]  len_q, len_d;
  logic [ADDR_WIDTH:0]  addr_q, addr_d;
  logic [1:0]           idx_q, idx_d;
  logic [INSTR_W-1:0]   shift_q, shift_d;
  logic                 done_q;

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state_q <= L_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      done_q  <= (state_q == L_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ready_o = 1'b0;
    we_o    = 1'b0;
    err_o   = 1'b0;
    case (state_q)
      L_IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            state_d = L_DONE;
          end else if (len_i > DEPTH_L) begin
            err_o = 1'b1;
          end else begin
            len_d   = len_i;
            addr_d  = '0;
            idx_d   = '0;
            state_d = L_BYTE;
          end
        end
      end
      L_BYTE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          // Shifting a full word's worth of bytes pushes byte 0's upper nibble off the top.
          shift_d = {shift_q[INSTR_W-LOAD_BYTE_W-1:0], byte_i};
          idx_d   = idx_q + 2'd1;
          if (idx_q == LAST_BYTE) begin
            state_d = L_WRITE;
          end
        end
      end
      L_WRITE: begin
        we_o   = 1'b1;
        addr_d = addr_q + 1'b1;
        state_d = (addr_d == len_q) ? L_DONE : L_BYTE;
      end
      L_DONE: begin
        state_d = L_IDLE;
      end
      default: begin
        state_d = L_IDLE;
      end
    endcase
  end

  assign busy_o  = (state_q != L_IDLE);
  assign done_o  = done_q;
  assign waddr_o = addr_q[IDX_W-1:0];
  assign wdata_o = shift_q;

endmodule
`default_nettype wire

// File: rtl/mest_pro_imem.sv
`default_nettype none
// ============================================================================
// mest_pro_imem : MEST Pro instruction memory with byte-serial program loader
// Revision      : 1.0
// ============================================================================
module mest_pro_imem #(
  parameter int OP_CODE_SIZE     = mest_pro_pkg::OP_CODE_SIZE,
  parameter int INSTRUCTION_SIZE = OP_CODE_SIZE + 24,
  parameter int MEM_DEPTH        = 256,
  parameter int ADDR_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        i_reset_n,
  input  logic                        i_req,
  input  logic [ADDR_WIDTH-1:0]       i_prog_counter,
  input  logic                        i_cs,
  input  logic                        i_we,
  input  logic [INSTRUCTION_SIZE-1:0] i_data2store,
  input  logic                        i_mem_reset,
  output logic [INSTRUCTION_SIZE-1:0] o_instruction,
  output logic                        o_valid,
  output logic                        m_ERROR,
  input  logic                        i_load_start,
  input  logic [ADDR_WIDTH:0]         i_load_len,
  input  logic                        i_load_valid,
  input  logic [7:0]                  i_load_byte,
  output logic                        o_load_ready,
  output logic                        o_load_busy,
  output logic                        o_load_done
);

  localparam int                  IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [INSTRUCTION_SIZE-1:0] mem [MEM_DEPTH];

  logic                        ld_busy, ld_err, ld_we;
  logic [IDX_W-1:0]            ld_waddr;
  logic [INSTRUCTION_SIZE-1:0] ld_wdata;

  logic                        in_range, access;
  logic                        wr_en;
  logic [IDX_W-1:0]            wr_addr;
  logic [INSTRUCTION_SIZE-1:0] wr_data;

  logic [INSTRUCTION_SIZE-1:0] instr_q, instr_d;
  logic                        valid_q, valid_d;
  logic                        err_q, err_d;

  mest_pro_imem_loader #(
    .INSTR_W    (INSTRUCTION_SIZE),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W)
  ) u_loader (
    .clk      (clk),
    .reset_ni (i_reset_n),
    .start_i  (i_load_start),
    .len_i    (i_load_len),
    .valid_i  (i_load_valid),
    .byte_i   (i_load_byte),
    .ready_o  (o_load_ready),
    .busy_o   (ld_busy),
    .done_o   (o_load_done),
    .err_o    (ld_err),
    .we_o     (ld_we),
    .waddr_o  (ld_waddr),
    .wdata_o  (ld_wdata)
  );

  assign in_range = ({1'b0, i_prog_counter} < DEPTH_L);
  assign access   = i_req & i_cs & ~ld_busy;

  // Single write port: the loader wins; core writes are already locked out while it is busy.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = i_prog_counter[IDX_W-1:0];
    wr_data = i_data2store;
    if (ld_we) begin
      wr_en   = 1'b1;
      wr_addr = ld_waddr;
      wr_data = ld_wdata;
    end else if (access && i_we && in_range) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && i_reset_n) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    instr_d = instr_q;
    valid_d = 1'b0;
    err_d   = ld_err;
    if (i_req && i_cs) begin
      if (ld_busy) begin
        err_d = 1'b1;
      end else if (!i_we) begin
        valid_d = 1'b1;
        if (in_range) begin
          instr_d = mem[i_prog_counter[IDX_W-1:0]];
        end else begin
          instr_d = '0;
          err_d   = 1'b1;
        end
      end else if (!in_range) begin
        err_d = 1'b1;
      end
    end
    if (i_mem_reset) begin
      instr_d = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_valid       = valid_q;
  assign m_ERROR       = err_q;
  assign o_load_busy   = ld_busy;

endmodule
`default_nettype wire

// File: tb/tb_mest_pro_imem.sv
`default_nettype none
// ============================================================================
// tb_mest_pro_imem : self-checking bench for the MEST Pro instruction memory
// Revision         : 1.0
// ============================================================================
module tb_mest_pro_imem;

  localparam int IW    = 28;
  localparam int DEPTH = 256;
  localparam int AW    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset_n, i_req, i_cs, i_we, i_mem_reset;
  logic [AW-1:0] i_prog_counter;
  logic [IW-1:0] i_data2store;
  logic          i_load_start, i_load_valid;
  logic [AW:0]   i_load_len;
  logic [7:0]    i_load_byte;
  logic [IW-1:0] o_instruction;
  logic          o_valid, m_ERROR, o_load_ready, o_load_busy, o_load_done;

  mest_pro_imem #(
    .OP_CODE_SIZE (4), .INSTRUCTION_SIZE (IW), .MEM_DEPTH (DEPTH), .ADDR_WIDTH (AW)
  ) dut (
    .clk (clk), .i_reset_n (i_reset_n), .i_req (i_req), .i_prog_counter (i_prog_counter),
    .i_cs (i_cs), .i_we (i_we), .i_data2store (i_data2store), .i_mem_reset (i_mem_reset),
    .o_instruction (o_instruction), .o_valid (o_valid), .m_ERROR (m_ERROR),
    .i_load_start (i_load_start), .i_load_len (i_load_len), .i_load_valid (i_load_valid),
    .i_load_byte (i_load_byte), .o_load_ready (o_load_ready), .o_load_busy (o_load_busy),
    .o_load_done (o_load_done)
  );

  int            n_total = 0;
  int            n_bad   = 0;
  int            cyc     = 0;
  logic [IW-1:0] ref_mem [DEPTH];
  logic [IW-1:0] exp_instr;
  logic [7:0]    byte_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic core_idle();
    i_req = 1'b0; i_cs = 1'b0; i_we = 1'b0; i_mem_reset = 1'b0;
    i_prog_counter = '0; i_data2store = '0;
  endtask

  task automatic core_read(input int addr);
    i_req = 1'b1; i_cs = 1'b1; i_we = 1'b0; i_prog_counter = AW'(addr);
    step();
    core_idle();
  endtask

  task automatic feed_byte(input logic [7:0] b);
    int g;
    i_load_valid = 1'b1;
    i_load_byte  = b;
    g = 0;
    while (!o_load_ready && g < 20) begin
      step();
      g++;
    end
    if (!o_load_ready) chk("ld_ready_wait", o_load_ready, 1);
    step();
    i_load_valid = 1'b0;
  endtask

  function automatic logic [IW-1:0] word_of(input int w);
    logic [7:0] b0;
    b0 = byte_q[4*w];
    return {b0[3:0], byte_q[4*w+1], byte_q[4*w+2], byte_q[4*w+3]};
  endfunction

  // Loads n words from byte_q; optionally pokes a core access on byte index 'poke'.
  task automatic load_run(input int n, input bit gaps, input int poke, input bit poke_we,
                          output int lat);
    int c0, g;
    c0 = cyc;
    i_load_start = 1'b1;
    i_load_len   = (AW + 1)'(n);
    step();
    i_load_start = 1'b0;
    chk("ld_busy_start", o_load_busy, 1);
    for (int k = 0; k < 4 * n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) step();
      if (k == poke) begin
        i_req = 1'b1; i_cs = 1'b1; i_we = poke_we;
        i_prog_counter = 16'd5; i_data2store = 28'h5A5A5A5;
      end
      feed_byte(byte_q[k]);
      if (k == 0) c0 = cyc;
      if (k == poke) begin
        chk("busy_access_valid", o_valid, 0);
        chk("busy_access_err", m_ERROR, 1);
        core_idle();
      end
    end
    g = 0;
    while (!o_load_done && g < 20) begin
      step();
      g++;
    end
    chk("ld_done_pulse", o_load_done, 1);
    lat = cyc - c0;
    step();
    chk("ld_done_single", o_load_done, 0);
    chk("ld_busy_end", o_load_busy, 0);
    for (int w = 0; w < n; w++) ref_mem[w] = word_of(w);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat, op, addr;
    logic [IW-1:0] data, w3 [3];
    logic          ev, ee;

    w3[0] = 28'hA123456; w3[1] = 28'h0FF00FF; w3[2] = 28'h1000001;
    core_idle();
    i_reset_n = 1'b0; i_load_start = 1'b0; i_load_len = '0;
    i_load_valid = 1'b0; i_load_byte = '0;
    step(); step();
    chk("rst_instr", o_instruction, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_err", m_ERROR, 0);
    chk("rst_busy", o_load_busy, 0);
    chk("rst_ready", o_load_ready, 0);
    chk("rst_done", o_load_done, 0);
    i_reset_n = 1'b1;
    step();

    // Fill every word with random data, with random valid gaps (len = depth is legal).
    byte_q.delete();
    for (int i = 0; i < 4 * DEPTH; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    load_run(DEPTH, 1'b1, -1, 1'b0, lat);

    byte_q = '{8'hFA, 8'h12, 8'h34, 8'h56, 8'h00, 8'hFF, 8'h00, 8'hFF,
               8'h01, 8'h00, 8'h00, 8'h01};
    load_run(3, 1'b0, -1, 1'b0, lat);
    chk("ld_done_latency", lat, 15);
    i_req = 1'b1; i_cs = 1'b1; i_we = 1'b0;
    for (int a = 0; a < 3; a++) begin
      i_prog_counter = AW'(a);
      step();
      chk("rd3_data", o_instruction, w3[a]);
      chk("rd3_valid", o_valid, 1);
    end
    core_idle();
    step();
    chk("hold_instr", o_instruction, w3[2]);
    chk("hold_valid", o_valid, 0);

    core_read(256);
    chk("oor_rd_instr", o_instruction, 0);
    chk("oor_rd_valid", o_valid, 1);
    chk("oor_rd_err", m_ERROR, 1);
    step();
    chk("err_single", m_ERROR, 0);

    i_req = 1'b1; i_cs = 1'b1; i_we = 1'b1; i_prog_counter = 16'd10; i_data2store = 28'h7654321;
    step();
    core_idle();
    ref_mem[10] = 28'h7654321;
    chk("wr_valid", o_valid, 0);
    chk("wr_err", m_ERROR, 0);
    core_read(10);
    chk("raw_data", o_instruction, ref_mem[10]);

    i_req = 1'b1; i_cs = 1'b1; i_we = 1'b1; i_prog_counter = 16'd300; i_data2store = 28'h1111111;
    step();
    core_idle();
    chk("oor_wr_err", m_ERROR, 1);
    core_read(44);
    chk("oor_wr_dropped", o_instruction, ref_mem[44]);

    byte_q.delete();
    for (int i = 0; i < 8; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    load_run(2, 1'b0, 3, 1'b0, lat);
    load_run(2, 1'b1, 6, 1'b1, lat);
    for (int a = 0; a < 2; a++) begin
      core_read(a);
      chk("ld_poke_word", o_instruction, ref_mem[a]);
    end
    core_read(5);
    chk("busy_wr_dropped", o_instruction, ref_mem[5]);

    i_load_start = 1'b1; i_load_len = '0;
    step();
    i_load_start = 1'b0;
    chk("len0_busy", o_load_busy, 1);
    chk("len0_done_early", o_load_done, 0);
    step();
    chk("len0_done", o_load_done, 1);
    chk("len0_idle", o_load_busy, 0);

    i_load_start = 1'b1; i_load_len = 17'd257;
    step();
    i_load_start = 1'b0;
    chk("len257_err", m_ERROR, 1);
    chk("len257_busy", o_load_busy, 0);
    chk("len257_ready", o_load_ready, 0);

    // Abort a 4-word load after two words have been written.
    byte_q.delete();
    for (int i = 0; i < 16; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    i_load_start = 1'b1; i_load_len = 17'd4;
    step();
    i_load_start = 1'b0;
    for (int k = 0; k < 9; k++) feed_byte(byte_q[k]);
    i_reset_n = 1'b0;
    step();
    chk("abort_busy", o_load_busy, 0);
    chk("abort_ready", o_load_ready, 0);
    chk("abort_instr", o_instruction, 0);
    chk("abort_valid", o_valid, 0);
    i_reset_n = 1'b1;
    step();
    ref_mem[0] = word_of(0);
    ref_mem[1] = word_of(1);
    for (int a = 0; a < 3; a++) begin
      core_read(a);
      chk("abort_keep", o_instruction, ref_mem[a]);
    end

    i_req = 1'b1; i_cs = 1'b1; i_prog_counter = 16'd1; i_mem_reset = 1'b1;
    step();
    chk("mrst_instr", o_instruction, 0);
    chk("mrst_valid", o_valid, 0);
    i_prog_counter = 16'd280;
    step();
    core_idle();
    chk("mrst_err", m_ERROR, 0);
    exp_instr = '0;

    for (int it = 0; it < 400; it++) begin
      op   = int'($urandom_range(0, 9));
      addr = int'($urandom_range(0, 299));
      data = IW'($urandom);
      core_idle();
      i_prog_counter = AW'(addr);
      i_data2store   = data;
      ev = 1'b0; ee = 1'b0;
      if (op <= 4 || op == 8) begin
        i_req = 1'b1; i_cs = 1'b1;
        i_mem_reset = (op == 8);
        if (op == 8) begin
          exp_instr = '0;
        end else begin
          ev = 1'b1;
          ee = (addr >= DEPTH);
          exp_instr = (addr < DEPTH) ? ref_mem[addr] : '0;
        end
      end else if (op <= 6) begin
        i_req = 1'b1; i_cs = 1'b1; i_we = 1'b1;
        ee = (addr >= DEPTH);
        if (addr < DEPTH) ref_mem[addr] = data;
      end else if (op == 9) begin
        i_req = 1'b1;
      end
      step();
      chk("rnd_instr", o_instruction, exp_instr);
      chk("rnd_valid", o_valid, ev);
      chk("rnd_err", m_ERROR, ee);
    end
    core_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
